// File: rtl/tick_event_scheduler.sv
// Periodic event generator: per-channel tick counters feeding pending bits,
// drained through one round-robin arbitrated valid/ready event port.
module tick_event_scheduler #(
    parameter  int N_CH  = 4,
    parameter  int CNT_W = 8,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_en,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CH_W-1:0]  ev_ch,
    output logic [N_CH-1:0]  overrun,
    input  logic             overrun_clr
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  period [N_CH];
    logic [CNT_W-1:0]  cnt    [N_CH];
    logic [N_CH-1:0]   en;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   pending_nxt;
    logic [N_CH-1:0]   ovr_set;
    logic [N_CH-1:0]   fire;
    logic [N_CH-1:0]   cfg_hit;
    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   gnt_mask;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   idx_c;
    logic              gnt_found;
    logic              grant;

    assign ev_valid = (state == PRESENT);

    always_comb begin
        fire    = '0;
        cfg_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
            fire[i]    = tick && en[i] && (period[i] != '0)
                         && (cnt[i] == period[i] - 1'b1);
        end
    end

    // A channel being rewritten this cycle drops its pending event, so it
    // must not be granted either.
    assign eligible = pending & ~cfg_hit;

    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        idx_c     = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx_c = CH_W'((int'(last_grant) + k) % N_CH);
            if (!gnt_found && eligible[idx_c]) begin
                gnt_found = 1'b1;
                gnt_ch    = idx_c;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_found) begin
                    grant     = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (ev_ready) begin
                    if (gnt_found) grant = 1'b1;
                    else           state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_mask = '0;
        if (grant) gnt_mask[gnt_ch] = 1'b1;
    end

    // Priority per channel: config write, then a fire, then the grant.
    always_comb begin
        pending_nxt = pending;
        ovr_set     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_hit[i])       pending_nxt[i] = 1'b0;
            else if (fire[i])     pending_nxt[i] = 1'b1;
            else if (gnt_mask[i]) pending_nxt[i] = 1'b0;
            ovr_set[i] = fire[i] && pending[i]
                         && !gnt_mask[i] && !cfg_hit[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
            en         <= '0;
            pending    <= '0;
            overrun    <= '0;
            ev_ch      <= '0;
            last_grant <= CH_W'(N_CH - 1);
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_hit[i]) begin
                    period[i] <= cfg_period;
                    en[i]     <= cfg_en;
                    cnt[i]    <= '0;
                end else if (tick && en[i] && period[i] != '0) begin
                    cnt[i] <= fire[i] ? '0 : cnt[i] + 1'b1;
                end
            end
            pending <= pending_nxt;
            overrun <= (overrun & ~{N_CH{overrun_clr}}) | ovr_set;
            if (grant) begin
                ev_ch      <= gnt_ch;
                last_grant <= gnt_ch;
            end
        end
    end

endmodule

// File: tb/tb_tick_event_scheduler.sv
// Bench for tick_event_scheduler: table-driven single-channel runs plus
// directed multi-cycle sequences, with a scoreboard of expected events.
module tb_tick_event_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic       cfg_en;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_ch;
    logic [3:0] overrun;
    logic       overrun_clr;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;
    int sb[$];
    int seen;

    typedef struct {
        int ch;
        int period;
        int en;
        int n_ticks;
        int exp_ev;
    } vec_t;

    vec_t tbl[7];

    tick_event_scheduler #(.N_CH(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_period(cfg_period),
        .cfg_en(cfg_en),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_ch(ev_ch),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Accepted events are popped from the scoreboard away from the edge.
    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            acc_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got ch %0d, required none", ev_ch);
            end else begin
                check("sb_event_ch", int'(ev_ch), sb.pop_front());
            end
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic cfg(input int ch, input int p, input int e);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = 8'(p);
        cfg_en     = e[0];
        clk1();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        check("sb_drain", sb.size(), 0);
        sb.delete();
        rst_n = 1'b0;
        clk1();
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{ch: 0, period: 2,   en: 1, n_ticks: 8,  exp_ev: 4};
        tbl[1] = '{ch: 1, period: 5,   en: 1, n_ticks: 10, exp_ev: 2};
        tbl[2] = '{ch: 2, period: 0,   en: 1, n_ticks: 6,  exp_ev: 0};
        tbl[3] = '{ch: 3, period: 3,   en: 0, n_ticks: 9,  exp_ev: 0};
        tbl[4] = '{ch: 3, period: 1,   en: 1, n_ticks: 5,  exp_ev: 5};
        tbl[5] = '{ch: 1, period: 255, en: 1, n_ticks: 4,  exp_ev: 0};
        tbl[6] = '{ch: 2, period: 4,   en: 1, n_ticks: 12, exp_ev: 3};

        rst_n = 1'b0;
        tick = 1'b0;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_period = '0;
        cfg_en = 1'b0;
        ev_ready = 1'b0;
        overrun_clr = 1'b0;
        #12;
        check("rst_valid", ev_valid, 0);
        check("rst_ch", ev_ch, 0);
        check("rst_overrun", overrun, 0);
        clk1();
        rst_n = 1'b1;

        // Single channel, P=3, tick every 4 clocks
        ev_ready = 1'b1;
        cfg(0, 3, 1);
        for (int k = 1; k <= 9; k++) begin
            do_tick();
            if (k % 3 == 0) sb.push_back(0);
            if (k == 3) check("t1_not_same_cycle", ev_valid, 0);
            clk1();
            check("t1_valid", ev_valid, int'(k % 3 == 0));
            if (k % 3 == 0) check("t1_ch", ev_ch, 0);
            clk1();
            clk1();
        end

        // All channels every tick: back-to-back rotation
        do_reset();
        ev_ready = 1'b1;
        for (int c = 0; c < 4; c++) cfg(c, 1, 1);
        for (int r = 0; r < 2; r++) begin
            do_tick();
            for (int c = 0; c < 4; c++) sb.push_back(c);
            for (int c = 0; c < 4; c++) begin
                clk1();
                check("t2_valid", ev_valid, 1);
                check("t2_rot_ch", ev_ch, c);
            end
            clk1();
            check("t2_idle", ev_valid, 0);
        end

        // Stalled consumer: hold, overrun, then drain
        do_reset();
        ev_ready = 1'b0;
        cfg(1, 2, 1);
        for (int k = 1; k <= 6; k++) begin
            do_tick();
            if (k == 2 || k == 4) sb.push_back(1);
            clk1();
            check("t3_valid", ev_valid, int'(k >= 2));
            if (k >= 2) check("t3_hold_ch", ev_ch, 1);
            check("t3_overrun", overrun, (k >= 6) ? 2 : 0);
            clk1();
            clk1();
        end
        ev_ready = 1'b1;
        clk1();
        check("t3_regrant", ev_valid, 1);
        check("t3_regrant_ch", ev_ch, 1);
        clk1();
        check("t3_drained", ev_valid, 0);
        cfg(1, 2, 0);

        // overrun_clr colliding with a fresh overrun
        check("t6_sticky", overrun, 2);
        overrun_clr = 1'b1;
        clk1();
        overrun_clr = 1'b0;
        check("t6_clr", overrun, 0);
        ev_ready = 1'b0;
        cfg(1, 1, 1);
        do_tick();
        sb.push_back(1);
        clk1();
        check("t6_present", ev_valid, 1);
        do_tick();
        sb.push_back(1);
        check("t6_no_ovr", overrun, 0);
        clk1();
        tick = 1'b1;
        overrun_clr = 1'b1;
        clk1();
        tick = 1'b0;
        overrun_clr = 1'b0;
        check("t6_clr_vs_set", overrun, 2);
        ev_ready = 1'b1;
        clk1();
        clk1();
        check("t6_drained", ev_valid, 0);
        cfg(1, 1, 0);

        // Config write on the same cycle as the due tick
        do_reset();
        ev_ready = 1'b1;
        cfg(2, 4, 1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin
                tick = 1'b1;
                cfg_we = 1'b1;
                cfg_ch = 2'd2;
                cfg_period = 8'd4;
                cfg_en = 1'b1;
                clk1();
                tick = 1'b0;
                cfg_we = 1'b0;
            end else begin
                do_tick();
            end
            if (k == 8) sb.push_back(2);
            clk1();
            check("t4_valid", ev_valid, int'(k == 8));
            if (k == 8) check("t4_ch", ev_ch, 2);
            clk1();
            clk1();
        end

        // Disabled / zero-period channel, then async reset mid-presentation
        do_reset();
        ev_ready = 1'b1;
        cfg(3, 0, 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            do_tick();
            clk1();
            seen |= int'(ev_valid);
            clk1();
        end
        check("t5_p0_silent", seen, 0);
        cfg(3, 1, 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            do_tick();
            clk1();
            seen |= int'(ev_valid);
            clk1();
        end
        check("t5_en0_silent", seen, 0);
        ev_ready = 1'b0;
        cfg(0, 1, 1);
        cfg(1, 1, 1);
        do_tick();
        clk1();
        check("t5_present", ev_valid, 1);
        check("t5_present_ch", ev_ch, 0);
        do_tick();
        check("t5_ovr_before", overrun, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", ev_valid, 0);
        check("t5_async_ch", ev_ch, 0);
        check("t5_async_ovr", overrun, 0);
        clk1();
        clk1();
        rst_n = 1'b1;
        ev_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            do_tick();
            clk1();
            seen |= int'(ev_valid);
        end
        check("t5_discarded", seen, 0);
        cfg(1, 1, 1);
        cfg(0, 1, 1);
        do_tick();
        sb.push_back(0);
        sb.push_back(1);
        clk1();
        check("t5_lg_first", ev_ch, 0);
        clk1();
        check("t5_lg_second", ev_ch, 1);
        clk1();

        // Table-driven single-channel runs
        foreach (tbl[v]) begin
            do_reset();
            ev_ready = 1'b1;
            cfg(tbl[v].ch, tbl[v].period, tbl[v].en);
            acc_cnt = 0;
            for (int k = 1; k <= tbl[v].n_ticks; k++) begin
                do_tick();
                if (tbl[v].en != 0 && tbl[v].period > 0
                    && k % tbl[v].period == 0)
                    sb.push_back(tbl[v].ch);
                clk1();
                clk1();
            end
            clk1();
            clk1();
            check($sformatf("tbl%0d_count", v), acc_cnt, tbl[v].exp_ev);
            check($sformatf("tbl%0d_sb_empty", v), sb.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
